// File: rtl/bcd_sw_pkg.sv
// rtl/bcd_sw_pkg.sv - shared types and constants for the BCD stopwatch sequencer
package bcd_sw_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        LAP_RUN   = 3'd3,
        LAP_PAUSE = 3'd4
    } sw_state_t;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/sw_edge_detect.sv
// rtl/sw_edge_detect.sv - rising-edge detector for one conditioned button level
module sw_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_d;

    // Delay flop; resetting it high suppresses an event for a button held through reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_d <= RESET_VAL;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - stopwatch sequencer driving a 4-digit BCD counter
module bcd_stopwatch_ctrl
    import bcd_sw_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [15:0] cnt_q,
    output logic        cnt_inc,
    output logic        cnt_clr,
    output logic [15:0] disp_q,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);

    sw_state_t     state;
    sw_state_t     next_state;
    logic [PW-1:0] presc;
    logic [15:0]   lap_reg;

    logic ev_start_raw;
    logic ev_lap_raw;
    logic ev_clear_raw;

    // Prioritised events: clear > start > lap, losers in the same cycle are dropped
    logic ev_clear;
    logic ev_start;
    logic ev_lap;

    logic accept_clear;
    logic capture_lap;
    logic counting;
    logic term;

    sw_edge_detect #(.RESET_VAL(1'b1)) u_edge_start (
        .clk   (clk),
        .reset (reset),
        .level (btn_start),
        .pulse (ev_start_raw)
    );

    sw_edge_detect #(.RESET_VAL(1'b1)) u_edge_lap (
        .clk   (clk),
        .reset (reset),
        .level (btn_lap),
        .pulse (ev_lap_raw)
    );

    sw_edge_detect #(.RESET_VAL(1'b1)) u_edge_clear (
        .clk   (clk),
        .reset (reset),
        .level (btn_clear),
        .pulse (ev_clear_raw)
    );

    assign ev_clear = ev_clear_raw;
    assign ev_start = ev_start_raw & ~ev_clear_raw;
    assign ev_lap   = ev_lap_raw & ~ev_start_raw & ~ev_clear_raw;

    // Terminal count uses the current state so a stop in the same cycle still ticks
    assign counting = (state == RUN) || (state == LAP_RUN);
    assign term     = counting && (presc == PRESC_TERM);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the side-effect strobes tied to each transition
    always_comb begin
        next_state   = state;
        accept_clear = 1'b0;
        capture_lap  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ev_clear) begin
                    accept_clear = 1'b1;
                end else if (ev_start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (ev_start) begin
                    next_state = PAUSE;
                end else if (ev_lap) begin
                    next_state  = LAP_RUN;
                    capture_lap = 1'b1;
                end
            end
            PAUSE: begin
                if (ev_clear) begin
                    next_state   = IDLE;
                    accept_clear = 1'b1;
                end else if (ev_start) begin
                    next_state = RUN;
                end
            end
            LAP_RUN: begin
                if (ev_start) begin
                    next_state = LAP_PAUSE;
                end else if (ev_lap) begin
                    next_state = RUN;
                end
            end
            LAP_PAUSE: begin
                if (ev_clear) begin
                    next_state   = IDLE;
                    accept_clear = 1'b1;
                end else if (ev_start) begin
                    next_state = LAP_RUN;
                end else if (ev_lap) begin
                    next_state = PAUSE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-derived outputs and the display mux
    always_comb begin
        running    = (state == RUN) || (state == LAP_RUN);
        lap_active = (state == LAP_RUN) || (state == LAP_PAUSE);
        disp_q     = lap_active ? lap_reg : cnt_q;
    end

    // Prescaler, counter strobes, lap snapshot and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc    <= '0;
            cnt_inc  <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_reg  <= BCD_ZERO;
            overflow <= 1'b0;
        end else begin
            cnt_inc <= term;
            cnt_clr <= accept_clear;

            if (next_state == IDLE) begin
                presc <= '0;
            end else if (term) begin
                presc <= '0;
            end else if (counting) begin
                presc <= presc + 1'b1;
            end

            if (capture_lap) begin
                lap_reg <= cnt_q;
            end

            if (accept_clear) begin
                overflow <= 1'b0;
            end else if (term && (cnt_q == BCD_MAX)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Stopwatch sequencer for the 4-digit BCD counter.
- Turns three button levels (start/stop, lap, clear) into counter control: a prescaled one-cycle increment pulse and a one-cycle clear pulse.
- Freezes a lap snapshot for the display path.
- Flags wrap past 9999.
- Sits between the button conditioning logic and the BCD counter / display mux.

Parameters:
TICK_DIV, 500000, clk cycles per counter increment (50 MHz -> 100 Hz); legal range >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
btn_start  in  1  start/stop level, already synchronous to clk and debounced
btn_lap  in  1  lap level, synchronous and debounced
btn_clear  in  1  clear level, synchronous and debounced
cnt_q  in  16  live packed BCD value from the counter (digit3..digit0)
cnt_inc  out  1  one-cycle increment pulse to the counter
cnt_clr  out  1  one-cycle synchronous clear pulse to the counter
disp_q  out  16  display value: lap snapshot when frozen, else cnt_q
running  out  1  high in RUN and LAP_RUN
lap_active  out  1  high in LAP_RUN and LAP_PAUSE
overflow  out  1  sticky, set when an increment is issued while cnt_q == 16'h9999

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low on port reset.
- Reset values:
  - state IDLE, prescaler 0, cnt_inc 0, cnt_clr 0
  - lap_reg 16'h0000, overflow 0
  - button-delay flops = 1, so a button held through reset produces no event.
- Edge detect: event = btn & ~btn_d, with btn_d registered each cycle.
- Event priority per cycle: clear > start > lap. Lower-priority events in the same cycle are discarded.
- State transitions (taken on the clock edge that sees the event; outputs registered, visible next cycle):
  - IDLE: start -> RUN. clear -> stay, pulse cnt_clr. lap ignored.
  - RUN: start -> PAUSE. lap -> LAP_RUN, lap_reg <= cnt_q. clear ignored.
  - PAUSE: start -> RUN. clear -> IDLE + cnt_clr. lap ignored.
  - LAP_RUN: lap -> RUN (release freeze). start -> LAP_PAUSE. clear ignored.
  - LAP_PAUSE: start -> LAP_RUN. lap -> PAUSE. clear -> IDLE + cnt_clr, freeze released.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while the current state is RUN or LAP_RUN.
  - At TICK_DIV-1: wraps to 0 and cnt_inc is registered high for exactly one cycle.
  - The terminal count is evaluated on the current state, so a stop event in that same cycle still yields the pulse.
  - Holds its value in PAUSE/LAP_PAUSE, so the sub-tick fraction is preserved across pause.
  - Zeroed on entry to IDLE and on reset.
- Overflow:
  - Set on the cycle the increment is issued while cnt_q == 16'h9999; the counter itself wraps to 0000.
  - Remains set until a clear is accepted or reset.
- cnt_inc and cnt_clr are never high in the same cycle, because clear is only accepted in non-running states.
- disp_q = lap_active ? lap_reg : cnt_q (combinational mux). lap_reg is not cleared on lap release.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. No cnt_clr is issued; the counter has its own reset.

Decomposition:
- Package bcd_sw_pkg:
  - state enum (IDLE, RUN, PAUSE, LAP_RUN, LAP_PAUSE)
  - BCD_MAX = 16'h9999
  - BCD_ZERO = 16'h0000
- One sub-module: sw_edge_detect (flop + AND, parameterised delay-flop reset value), instantiated three times.
- Prescaler and FSM stay in the top module.

Test Plan:
(All cases TICK_DIV=4.)
1. Hold btn_start=1 through 3 reset-low cycles, release reset, keep btn_start high -> state stays IDLE, running=0, cnt_inc never pulses.
2. Start edge from IDLE -> running=1 next cycle; cnt_inc pulses exactly every 4 cycles, first pulse 4 cycles after RUN entry.
3. Start edge after 2 prescaler counts (PAUSE), idle 10 cycles, start again -> first cnt_inc 2 cycles after resume, then every 4.
4. In RUN with cnt_q=16'h0012, lap edge -> disp_q holds 0012 while cnt_inc continues; second lap edge -> disp_q tracks cnt_q, lap_active=0.
5. Clear edge in RUN -> ignored, no cnt_clr. Then start (PAUSE), then clear -> single-cycle cnt_clr, state IDLE, lap_active=0, overflow=0.
6. Drive cnt_q=16'h9999 while running -> overflow=1 with the next cnt_inc, stays 1. In PAUSE, start+clear edges in the same cycle -> clear wins, IDLE, running stays 0.
